// File: rtl/call_stack_pkg.sv
// ---------------------------------------------------------------------------
// call_stack_pkg : shared state, trap and value-type codes for the call stack
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package call_stack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_TRAP = 2'd2
  } cs_state_t;

  localparam logic [3:0] TRAP_NONE                 = 4'd0;
  localparam logic [3:0] TRAP_CALL_STACK_EXHAUSTED = 4'd5;
  localparam logic [3:0] TRAP_CALL_STACK_UNDERFLOW = 4'd6;

  localparam logic [1:0] TYPE_I32 = 2'd0;
  localparam logic [1:0] TYPE_I64 = 2'd1;
  localparam logic [1:0] TYPE_F32 = 2'd2;
  localparam logic [1:0] TYPE_F64 = 2'd3;

endpackage

`default_nettype wire

// File: rtl/call_stack_if.sv
// ---------------------------------------------------------------------------
// call_stack_if : push/pop handshake and status bundle of the call stack
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface call_stack_if #(
  parameter int ROM_ADDR   = 4,
  parameter int STACK_ADDR = 8,
  parameter int DEPTH_LOG2 = 4
);
  logic                  call_valid;
  logic                  call_ready;
  logic [ROM_ADDR-1:0]   call_pc;
  logic [STACK_ADDR-1:0] call_sp;
  logic                  call_arity;
  logic [1:0]            call_type;
  logic                  ret_valid;
  logic                  ret_ready;
  logic                  frame_valid;
  logic [ROM_ADDR-1:0]   frame_pc;
  logic [STACK_ADDR-1:0] frame_sp;
  logic                  frame_arity;
  logic [1:0]            frame_type;
  logic [DEPTH_LOG2:0]   depth;
  logic                  empty;
  logic                  full;
  logic [3:0]            trap;

  modport master (
    output call_valid, call_pc, call_sp, call_arity, call_type, ret_valid,
    input  call_ready, ret_ready, frame_valid, frame_pc, frame_sp,
           frame_arity, frame_type, depth, empty, full, trap
  );

  modport slave (
    input  call_valid, call_pc, call_sp, call_arity, call_type, ret_valid,
    output call_ready, ret_ready, frame_valid, frame_pc, frame_sp,
           frame_arity, frame_type, depth, empty, full, trap
  );
endinterface

`default_nettype wire

// File: rtl/call_stack_frame_ram.sv
// ---------------------------------------------------------------------------
// frame_ram : simple dual-port frame storage, synchronous write and read
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module frame_ram #(
  parameter int WIDTH      = 15,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  // No reset on storage or read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

`default_nettype wire

// File: rtl/call_stack.sv
// ---------------------------------------------------------------------------
// call_stack : WebAssembly call-frame stack with tail calls and trapping
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module call_stack
  import call_stack_pkg::*;
#(
  parameter int ROM_ADDR   = 4,
  parameter int STACK_ADDR = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input logic        clk,
  input logic        reset,
  call_stack_if.slave bus
);
  localparam int FRAME_W = ROM_ADDR + STACK_ADDR + 3;
  localparam logic [DEPTH_LOG2:0] DEPTH_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

  cs_state_t             state;
  logic [DEPTH_LOG2:0]   depth_q;
  logic                  ready_q;
  logic                  frame_valid_q;
  logic [ROM_ADDR-1:0]   frame_pc_q;
  logic [STACK_ADDR-1:0] frame_sp_q;
  logic                  frame_arity_q;
  logic [1:0]            frame_type_q;
  logic [3:0]            trap_q;

  logic                  is_idle, is_empty, is_full;
  logic                  do_call, do_tail, do_pop;
  logic [DEPTH_LOG2-1:0] top_idx;
  logic [FRAME_W-1:0]    wdata, rdata;

  assign is_idle  = (state == ST_IDLE);
  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == DEPTH_MAX);
  assign top_idx  = depth_q[DEPTH_LOG2-1:0] - 1'b1;

  assign do_call = is_idle && bus.call_valid && !bus.ret_valid && !is_full;
  assign do_tail = is_idle && bus.call_valid &&  bus.ret_valid && !is_empty;
  assign do_pop  = is_idle && bus.ret_valid  && !bus.call_valid && !is_empty;
  assign wdata   = {bus.call_pc, bus.call_sp, bus.call_arity, bus.call_type};

  frame_ram #(
    .WIDTH      (FRAME_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_frame_ram (
    .clk   (clk),
    .we    (do_call || do_tail),
    .waddr (do_tail ? top_idx : depth_q[DEPTH_LOG2-1:0]),
    .wdata (wdata),
    .re    (do_pop),
    .raddr (top_idx),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      depth_q       <= '0;
      ready_q       <= 1'b1;
      frame_valid_q <= 1'b0;
      frame_pc_q    <= '0;
      frame_sp_q    <= '0;
      frame_arity_q <= 1'b0;
      frame_type_q  <= '0;
      trap_q        <= TRAP_NONE;
    end else begin
      frame_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.call_valid && !bus.ret_valid) begin
            if (is_full) begin
              trap_q  <= TRAP_CALL_STACK_EXHAUSTED;
              state   <= ST_TRAP;
              ready_q <= 1'b0;
            end else begin
              depth_q <= depth_q + 1'b1;
            end
          end else if (bus.ret_valid) begin
            // A tail call on a live stack only rewrites the top frame in the RAM.
            if (is_empty) begin
              trap_q  <= TRAP_CALL_STACK_UNDERFLOW;
              state   <= ST_TRAP;
              ready_q <= 1'b0;
            end else if (!bus.call_valid) begin
              state   <= ST_READ;
              ready_q <= 1'b0;
            end
          end
        end
        ST_READ: begin
          {frame_pc_q, frame_sp_q, frame_arity_q, frame_type_q} <= rdata;
          frame_valid_q <= 1'b1;
          depth_q       <= depth_q - 1'b1;
          state         <= ST_IDLE;
          ready_q       <= 1'b1;
        end
        ST_TRAP: begin
          ready_q <= 1'b0;
        end
        default: begin
          state   <= ST_TRAP;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.call_ready  = ready_q;
  assign bus.ret_ready   = ready_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_pc    = frame_pc_q;
  assign bus.frame_sp    = frame_sp_q;
  assign bus.frame_arity = frame_arity_q;
  assign bus.frame_type  = frame_type_q;
  assign bus.depth       = depth_q;
  assign bus.empty       = is_empty;
  assign bus.full        = is_full;
  assign bus.trap        = trap_q;
endmodule

`default_nettype wire
